// File: rtl/srl64_tap_reg_if.sv
// Serial-in / tap-select bus for the 64-deep SRL delay line.
// The master drives shift control and tap address; the slave returns taps.
interface srl64_tap_reg_if;
    logic       CE;
    logic       D;
    logic [5:0] A;
    logic       Q;
    logic       Q_VLD;
    logic       Q63;

    modport master (
        output CE,
        output D,
        output A,
        input  Q,
        input  Q_VLD,
        input  Q63
    );

    modport slave (
        input  CE,
        input  D,
        input  A,
        output Q,
        output Q_VLD,
        output Q63
    );
endinterface

// File: rtl/srl64_tap_reg.sv
// 64-deep addressable SRL delay line: two cascaded 32-bit sections,
// a MUXF7-style section select on A[5], and an optional output flop.
module srl64_tap_reg #(
    parameter logic [63:0] INIT  = 64'h0,
    parameter logic        SRVAL = 1'b0,
    parameter int          OREG  = 1
) (
    input  logic             C,
    input  logic             R,
    srl64_tap_reg_if.slave   bus
);

    localparam logic [6:0] CNT_MAX = 7'd64;

    // SRL contents are power-up initialised only, never reset.
    logic [31:0] sr_lo = INIT[31:0];
    logic [31:0] sr_hi = INIT[63:32];
    logic [6:0]  cnt   = 7'd0;

    logic [4:0]  sub_a;
    logic        sel_hi;
    logic        lo;
    logic        hi;
    logic        tap;
    logic        vld;

    always_ff @(posedge C) begin
        if (bus.CE) begin
            sr_lo <= {sr_lo[30:0], bus.D};
            sr_hi <= {sr_hi[30:0], sr_lo[31]};
        end
    end

    always_ff @(posedge C) begin
        if (R) begin
            cnt <= 7'd0;
        end else if (bus.CE && (cnt < CNT_MAX)) begin
            cnt <= cnt + 7'd1;
        end
    end

    assign sub_a  = bus.A[4:0];
    assign sel_hi = bus.A[5];
    assign lo     = sr_lo[sub_a];
    assign hi     = sr_hi[sub_a];
    assign tap    = sel_hi ? hi : lo;
    assign vld    = (cnt > {1'b0, bus.A});

    assign bus.Q63 = sr_hi[31];

    generate
        if (OREG != 0) begin : g_oreg
            logic q_r;
            logic q_vld_r;

            always_ff @(posedge C) begin
                if (R) begin
                    q_r     <= SRVAL;
                    q_vld_r <= 1'b0;
                end else begin
                    q_r     <= tap;
                    q_vld_r <= vld;
                end
            end

            assign bus.Q     = q_r;
            assign bus.Q_VLD = q_vld_r;
        end else begin : g_comb
            assign bus.Q     = tap;
            assign bus.Q_VLD = vld;
        end
    endgenerate

endmodule

// File: tb/tb_srl64_tap_reg.sv
// Directed bench for srl64_tap_reg: reset, latency, section boundary,
// counter saturation, reset-with-shift and a full tap sweep.
module tb_srl64_tap_reg;

    localparam logic [63:0] INIT_V = 64'h8000_0000_0000_0001;
    localparam logic [63:0] PAT    = 64'hA5C3_0F96_1E2D_7B48;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    srl64_tap_reg_if bus ();

    srl64_tap_reg #(
        .INIT  (INIT_V),
        .SRVAL (1'b0),
        .OREG  (1)
    ) dut (
        .C   (clk),
        .R   (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        bus.CE = 1'b0;
        bus.D  = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        bus.CE = 1'b0;
        bus.D  = 1'b0;
        bus.A  = 6'd0;
        step();
        tests++;
        if (bus.Q !== 1'b0) begin
            fails++;
            $display("FAIL reset_q got %b want 0", bus.Q);
        end
        tests++;
        if (bus.Q_VLD !== 1'b0) begin
            fails++;
            $display("FAIL reset_vld got %b want 0", bus.Q_VLD);
        end
        rst = 1'b0;
        step();
        tests++;
        if (bus.Q !== 1'b1) begin
            fails++;
            $display("FAIL init_tap0 got %b want 1", bus.Q);
        end
        tests++;
        if (bus.Q_VLD !== 1'b0) begin
            fails++;
            $display("FAIL init_vld got %b want 0", bus.Q_VLD);
        end
        tests++;
        if (bus.Q63 !== 1'b1) begin
            fails++;
            $display("FAIL init_q63 got %b want 1", bus.Q63);
        end
        bus.A = 6'd63;
        step();
        tests++;
        if (bus.Q !== 1'b1) begin
            fails++;
            $display("FAIL init_tap63 got %b want 1", bus.Q);
        end
        bus.A = 6'd1;
        step();
        tests++;
        if (bus.Q !== 1'b0) begin
            fails++;
            $display("FAIL init_tap1 got %b want 0", bus.Q);
        end
    endtask

    task automatic test_latency();
        logic [3:0] bits;
        bits = 4'b1011;
        do_reset();
        bus.A  = 6'd3;
        bus.CE = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            bus.D = bits[i];
            step();
        end
        bus.CE = 1'b0;
        step();
        tests++;
        if (bus.Q !== 1'b1 || bus.Q_VLD !== 1'b1) begin
            fails++;
            $display("FAIL lat_a3 got %b/%b want 1/1", bus.Q, bus.Q_VLD);
        end
        bus.A = 6'd2;
        step();
        tests++;
        if (bus.Q !== 1'b0 || bus.Q_VLD !== 1'b1) begin
            fails++;
            $display("FAIL lat_a2 got %b/%b want 0/1", bus.Q, bus.Q_VLD);
        end
        // tap 4 holds INIT[0] pushed up by four shifts: readable, not valid
        bus.A = 6'd4;
        step();
        tests++;
        if (bus.Q !== 1'b1 || bus.Q_VLD !== 1'b0) begin
            fails++;
            $display("FAIL lat_a4 got %b/%b want 1/0", bus.Q, bus.Q_VLD);
        end
    endtask

    task automatic test_muxf7();
        do_reset();
        bus.A  = 6'd0;
        bus.CE = 1'b1;
        bus.D  = 1'b1;
        step();
        bus.D = 1'b0;
        for (int i = 0; i < 31; i++) step();
        bus.A = 6'd31;
        step();
        tests++;
        if (bus.Q !== 1'b1) begin
            fails++;
            $display("FAIL mux_a31_hit got %b want 1", bus.Q);
        end
        bus.CE = 1'b0;
        step();
        tests++;
        if (bus.Q !== 1'b0) begin
            fails++;
            $display("FAIL mux_a31_miss got %b want 0", bus.Q);
        end
        bus.A = 6'd32;
        step();
        tests++;
        if (bus.Q !== 1'b1 || bus.Q_VLD !== 1'b1) begin
            fails++;
            $display("FAIL mux_a32 got %b/%b want 1/1", bus.Q, bus.Q_VLD);
        end
        bus.CE = 1'b1;
        for (int i = 0; i < 31; i++) step();
        tests++;
        if (bus.Q63 !== 1'b1) begin
            fails++;
            $display("FAIL mux_q63_hit got %b want 1", bus.Q63);
        end
        step();
        tests++;
        if (bus.Q63 !== 1'b0) begin
            fails++;
            $display("FAIL mux_q63_next got %b want 0", bus.Q63);
        end
        bus.CE = 1'b0;
    endtask

    task automatic test_saturate();
        do_reset();
        bus.A  = 6'd0;
        bus.CE = 1'b1;
        for (int i = 0; i < 70; i++) begin
            bus.D = ((i % 3) == 0);
            step();
        end
        tests++;
        if (bus.Q63 !== 1'b1) begin
            fails++;
            $display("FAIL sat_q63 got %b want 1", bus.Q63);
        end
        bus.D = 1'b1;
        step();
        tests++;
        if (bus.Q63 !== 1'b0) begin
            fails++;
            $display("FAIL sat_q63_next got %b want 0", bus.Q63);
        end
        bus.CE = 1'b0;
        bus.A  = 6'd63;
        step();
        tests++;
        if (bus.Q !== 1'b0 || bus.Q_VLD !== 1'b1) begin
            fails++;
            $display("FAIL sat_a63 got %b/%b want 0/1", bus.Q, bus.Q_VLD);
        end
        bus.A = 6'd0;
        step();
        tests++;
        if (bus.Q !== 1'b1 || bus.Q_VLD !== 1'b1) begin
            fails++;
            $display("FAIL sat_a0 got %b/%b want 1/1", bus.Q, bus.Q_VLD);
        end
        bus.A = 6'd2;
        step();
        tests++;
        if (bus.Q !== 1'b0 || bus.Q_VLD !== 1'b1) begin
            fails++;
            $display("FAIL sat_a2 got %b/%b want 0/1", bus.Q, bus.Q_VLD);
        end
    endtask

    task automatic test_reset_shift();
        do_reset();
        bus.A  = 6'd0;
        bus.CE = 1'b1;
        bus.D  = 1'b0;
        for (int i = 0; i < 9; i++) step();
        bus.D = 1'b1;
        step();
        bus.D = 1'b0;
        rst   = 1'b1;
        step();
        tests++;
        if (bus.Q !== 1'b0 || bus.Q_VLD !== 1'b0) begin
            fails++;
            $display("FAIL rs_edge got %b/%b want 0/0", bus.Q, bus.Q_VLD);
        end
        rst    = 1'b0;
        bus.CE = 1'b0;
        bus.A  = 6'd1;
        step();
        tests++;
        if (bus.Q !== 1'b1 || bus.Q_VLD !== 1'b0) begin
            fails++;
            $display("FAIL rs_after got %b/%b want 1/0", bus.Q, bus.Q_VLD);
        end
        bus.A = 6'd0;
        step();
        tests++;
        if (bus.Q !== 1'b0 || bus.Q_VLD !== 1'b0) begin
            fails++;
            $display("FAIL rs_tap0 got %b/%b want 0/0", bus.Q, bus.Q_VLD);
        end
        bus.D = 1'b1;
        rst   = 1'b1;
        bus.CE = 1'b1;
        step();
        rst    = 1'b0;
        bus.CE = 1'b0;
        bus.D  = 1'b0;
        step();
        tests++;
        if (bus.Q !== 1'b1 || bus.Q_VLD !== 1'b0) begin
            fails++;
            $display("FAIL rs_d1 got %b/%b want 1/0", bus.Q, bus.Q_VLD);
        end
    endtask

    task automatic test_sweep();
        do_reset();
        bus.A  = 6'd0;
        bus.CE = 1'b1;
        for (int i = 63; i >= 0; i--) begin
            bus.D = PAT[i];
            step();
        end
        bus.CE = 1'b0;
        for (int i = 0; i < 10; i++) step();
        tests++;
        if (bus.Q63 !== PAT[63]) begin
            fails++;
            $display("FAIL sw_q63 got %b want %b", bus.Q63, PAT[63]);
        end
        for (int a = 0; a < 64; a++) begin
            bus.A = a[5:0];
            step();
            tests++;
            if (bus.Q !== PAT[a] || bus.Q_VLD !== 1'b1) begin
                fails++;
                $display("FAIL sw_a%0d got %b/%b want %b/1",
                         a, bus.Q, bus.Q_VLD, PAT[a]);
            end
        end
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        rst    = 1'b1;
        bus.CE = 1'b0;
        bus.D  = 1'b0;
        bus.A  = 6'd0;
        test_reset();
        test_latency();
        test_muxf7();
        test_saturate();
        test_reset_shift();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
